// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    DONE
  } seq_state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

endpackage

// File: rtl/seq_bit_counter.sv
// Loadable down-counter with a terminal-count flag; stops at zero.
module seq_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeat_cnt times.
// Define SEQ_GEN_GAP_EN to insert GAP_LEN zero bits between consecutive repeats.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int PAT_W   = 4,
  parameter int CNT_W   = 8,
  parameter int GAP_LEN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(PAT_W);

  seq_state_t       state, state_n;
  logic [PAT_W-1:0] pat_reg;
  logic [PAT_W-2:0] shreg;
  logic             out_n, valid_n, done_n;
  logic             pat_load, bit_load, bit_dec, rep_load, rep_dec;
  logic             bit_tc, rep_tc;

  seq_bit_counter #(.WIDTH(BW)) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (bit_load),
    .load_val (BW'(PAT_W - 1)),
    .dec      (bit_dec),
    .tc       (bit_tc)
  );

  // Holds the repeats still owed after the current one, so tc means "last repeat".
  seq_bit_counter #(.WIDTH(CNT_W)) u_rep_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (rep_load),
    .load_val (repeat_cnt - CNT_W'(1)),
    .dec      (rep_dec),
    .tc       (rep_tc)
  );

`ifdef SEQ_GEN_GAP_EN
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  logic gap_load, gap_dec, gap_tc;

  seq_bit_counter #(.WIDTH(GW)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GW'(GAP_LEN - 1)),
    .dec      (gap_dec),
    .tc       (gap_tc)
  );
`else
  logic unused_gap_len;
  assign unused_gap_len = (GAP_LEN != 0);
`endif

  always_comb begin
    state_n  = state;
    out_n    = 1'b0;
    valid_n  = 1'b0;
    done_n   = 1'b0;
    pat_load = 1'b0;
    bit_load = 1'b0;
    bit_dec  = 1'b0;
    rep_load = 1'b0;
    rep_dec  = 1'b0;
`ifdef SEQ_GEN_GAP_EN
    gap_load = 1'b0;
    gap_dec  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (repeat_cnt != '0) begin
            state_n  = SHIFT;
            pat_load = 1'b1;
            bit_load = 1'b1;
            rep_load = 1'b1;
            out_n    = pattern[PAT_W-1];
            valid_n  = 1'b1;
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (!bit_tc) begin
          bit_dec = 1'b1;
          out_n   = shreg[PAT_W-2];
          valid_n = 1'b1;
        end else if (rep_tc) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          rep_dec = 1'b1;
          valid_n = 1'b1;
`ifdef SEQ_GEN_GAP_EN
          state_n  = GAP;
          gap_load = 1'b1;
`else
          bit_load = 1'b1;
          out_n    = pat_reg[PAT_W-1];
`endif
        end
      end
`ifdef SEQ_GEN_GAP_EN
      GAP: begin
        valid_n = 1'b1;
        if (gap_tc) begin
          state_n  = SHIFT;
          bit_load = 1'b1;
          out_n    = pat_reg[PAT_W-1];
        end else begin
          gap_dec = 1'b1;
        end
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // shreg holds the bits still to come in the current repeat, next one at the top.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
      pat_reg   <= '0;
      shreg     <= '0;
    end else begin
      state     <= state_n;
      ser_out   <= out_n;
      ser_valid <= valid_n;
      done      <= done_n;
      if (pat_load) begin
        pat_reg <= pattern;
        shreg   <= pattern[PAT_W-2:0];
      end else if (bit_load) begin
        shreg <= pat_reg[PAT_W-2:0];
      end else if (bit_dec) begin
        shreg <= shreg << 1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
